mac_rx_fcs_check: RTL and testbench
===================================

Name: mac_rx_fcs_check

Overview:
- Byte-stream stage directly downstream of mac_rx, in the mac_clk domain.
- Consumes post-SFD frame bytes, i.e. destination MAC through FCS. Preamble and SFD are already stripped upstream.
- Runs CRC-32 over the whole frame and strips the 4 FCS bytes through a 4-byte delay line.
- Emits the payload with end-of-frame status flags: CRC error, runt, giant, PHY error.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes including FCS.
- MAX_LEN, 1518, maximum legal frame length in bytes including FCS.
- LEN_W, 11, width of the byte-length counter. It saturates at 2^LEN_W-1.

Ports:
- clk  in  1  mac_clk; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a frame byte this cycle.
- in_data  in  8  frame byte, first-received byte first.
- in_last  in  1  qualified by in_valid; marks the final byte of the frame (the last FCS byte).
- in_err  in  1  qualified by in_valid; PHY receive error seen on this byte.
- out_valid  out  1  out_data valid; single-cycle per byte, no backpressure.
- out_data  out  8  payload byte (FCS removed).
- out_last  out  1  with out_valid; last payload byte of the frame.
- out_good  out  1  with out_last; 1 only when out_status==0.
- out_status  out  4  with out_last: bit0 crc_err, bit1 runt, bit2 giant, bit3 phy_err.
- out_drop  out  1  one-cycle pulse; a frame of 1–4 bytes ended and no output was produced.

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0xFFFFFFFF, length 0, fill 0, sticky error 0.
- in_valid gaps inside a frame are legal; nothing advances when in_valid=0.
- in_last and in_err are ignored when in_valid=0.

State machine:
- IDLE: on in_valid, load the byte into delay slot 0, set len=1 and fill=1, start the CRC from 0xFFFFFFFF, and latch in_err. Go to FILL. If in_last is also set, instead pulse out_drop next cycle and stay in IDLE.
- FILL (fill<4): shift each byte in and increment fill.
  - If a byte arrives with fill==4 already, the oldest byte is pushed out; go to PASS.
  - in_last while in FILL (total length ≤4): pulse out_drop, return to IDLE, emit no out_valid.
- PASS: each in_valid shifts in one byte and pushes the oldest slot out. out_valid and out_data are registered, so output appears 1 cycle after the pushing input byte.
- in_last in PASS: the byte pushed out on that cycle is marked out_last. The 4 bytes remaining are the FCS and are discarded. Go to IDLE.

CRC:
- IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF.
- The CRC is updated for every byte including the FCS bytes.
- The next-state CRC is combinational, so the check includes the in_last byte in the same cycle.
- crc_err = (next CRC != residue 0xDEBB20E3).

Length and status:
- len counts every byte including FCS and saturates.
- runt = len<MIN_LEN; giant = len>MAX_LEN.
- phy_err = OR of in_err across the frame.
- Bytes are never suppressed for length or error reasons; status is reported only at out_last.

Boundaries:
- Frame of exactly 5 bytes gives 1 payload byte with out_last, and runt=1.
- A new frame may start the cycle after in_last; the clean IDLE reload handles back-to-back frames.
- Reset asserted mid-frame: the frame is discarded immediately, with no out_last and no out_drop.

Optional Feature:
MAC_RX_STATS_EN
- Defined: adds input stat_clr (1) and outputs stat_good, stat_crc_err, stat_len_err, stat_drop (32 bits each).
  - Counters increment on out_last (good / crc_err / runt-or-giant) and on out_drop.
  - They saturate at 0xFFFFFFFF.
  - stat_clr zeroes them synchronously; stat_clr wins over a simultaneous increment.
  - Reset clears them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- 64-byte frame (60 bytes 0x00–0x3B plus correct FCS), in_valid every 2nd cycle -> 60 out_valid bytes matching the input; out_last on byte 60; out_good=1, out_status=0.
- Same frame with byte 10 XOR 0x01 -> 60 bytes output; out_status=4'b0001, out_good=0.
- 20-byte frame with correct FCS -> 16 bytes output; out_status=4'b0010.
- 1522-byte frame with correct FCS -> 1518 bytes output; out_status=4'b0100.
- 3-byte frame -> no out_valid; out_drop pulses once.
- Back-to-back 64-byte frames, the second starting the cycle after in_last -> both good.
- in_err on byte 30 -> status bit3 set.
- rst low at byte 40 then released, then a good 64-byte frame -> no out_last for the aborted frame; the next frame is good.

Source files
------------

// File: rtl/mac_rx_fcs_check.sv
// mac_rx_fcs_check
//   Sits directly after mac_rx. Takes post-SFD frame bytes (destination MAC
//   through FCS), runs CRC-32 across the whole frame, and strips the 4 FCS
//   bytes with a 4-byte delay line. Length/CRC/PHY status is attached to the
//   last payload byte.
//
// Optional feature macro: MAC_RX_STATS_EN (adds saturating frame counters).
//
// Ports
//   clk          mac_clk, all logic on rising edge
//   rst          asynchronous active-low reset
//   in_valid     in_data carries a frame byte
//   in_data      frame byte, first-received first
//   in_last      final byte of the frame (last FCS byte)
//   in_err       PHY receive error on this byte
//   out_valid    one payload byte this cycle (no backpressure)
//   out_data     payload byte, FCS removed
//   out_last     last payload byte of the frame
//   out_good     with out_last, set only when out_status == 0
//   out_status   with out_last: {phy_err, giant, runt, crc_err}
//   out_drop     one-cycle pulse: a 1..4 byte frame ended with no output
//   stat_clr     (MAC_RX_STATS_EN) synchronous counter clear
//   stat_*       (MAC_RX_STATS_EN) 32-bit saturating counters

module mac_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_err,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_good,
    output logic [3:0] out_status,
    output logic       out_drop
`ifdef MAC_RX_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_good,
    output logic [31:0] stat_crc_err,
    output logic [31:0] stat_len_err,
    output logic [31:0] stat_drop
`endif
);

    localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]      CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [LEN_W-1:0] MIN_L       = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L       = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

    state_t           state;
    logic [3:0][7:0]  dly;      // dly[3] is the oldest byte
    logic [2:0]       fill;
    logic [LEN_W-1:0] len;
    logic [31:0]      crc;
    logic             phy_err;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    // In IDLE the accumulators restart from their initial values, so a new
    // frame the cycle after in_last never sees stale state.
    logic [31:0]      crc_seed, crc_nxt;
    logic [LEN_W-1:0] len_base, len_nxt;
    logic [2:0]       fill_base;
    logic             phy_nxt;
    logic             emit;
    logic [3:0]       status_nxt;

    always_comb begin
        crc_seed   = (state == IDLE) ? CRC_INIT : crc;
        len_base   = (state == IDLE) ? '0 : len;
        fill_base  = (state == IDLE) ? 3'd0 : fill;
        crc_nxt    = crc32_byte(crc_seed, in_data);
        len_nxt    = (&len_base) ? len_base : len_base + LEN_W'(1);
        phy_nxt    = in_err | ((state != IDLE) & phy_err);
        // A byte arriving with the delay line full pushes the oldest one out.
        emit       = (state != IDLE) && (fill_base == 3'd4);
        status_nxt = {phy_nxt, (len_nxt > MAX_L), (len_nxt < MIN_L), (crc_nxt != CRC_RESIDUE)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dly        <= '0;
            fill       <= '0;
            len        <= '0;
            crc        <= CRC_INIT;
            phy_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_good   <= 1'b0;
            out_status <= '0;
            out_drop   <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_good   <= 1'b0;
            out_status <= '0;
            out_drop   <= 1'b0;
            if (in_valid) begin
                dly <= {dly[2:0], in_data};
                if (emit) begin
                    out_valid <= 1'b1;
                    out_data  <= dly[3];
                end
                if (in_last) begin
                    // The 4 bytes left in the delay line are the FCS; drop them.
                    state   <= IDLE;
                    crc     <= CRC_INIT;
                    len     <= '0;
                    fill    <= '0;
                    phy_err <= 1'b0;
                    if (emit) begin
                        out_last   <= 1'b1;
                        out_status <= status_nxt;
                        out_good   <= (status_nxt == 4'd0);
                    end else begin
                        out_drop   <= 1'b1;
                    end
                end else begin
                    crc     <= crc_nxt;
                    len     <= len_nxt;
                    phy_err <= phy_nxt;
                    if (emit) begin
                        state <= PASS;
                    end else begin
                        fill  <= fill_base + 3'd1;
                        state <= FILL;
                    end
                end
            end
        end
    end

`ifdef MAC_RX_STATS_EN
    // Counters key off the registered end-of-frame outputs.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_good    <= '0;
            stat_crc_err <= '0;
            stat_len_err <= '0;
            stat_drop    <= '0;
        end else if (stat_clr) begin
            stat_good    <= '0;
            stat_crc_err <= '0;
            stat_len_err <= '0;
            stat_drop    <= '0;
        end else begin
            if (out_last && out_good)
                stat_good <= sat_inc(stat_good);
            if (out_last && out_status[0])
                stat_crc_err <= sat_inc(stat_crc_err);
            if (out_last && (out_status[1] || out_status[2]))
                stat_len_err <= sat_inc(stat_len_err);
            if (out_drop)
                stat_drop <= sat_inc(stat_drop);
        end
    end
`endif

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Scoreboard bench for mac_rx_fcs_check: the driver pushes the expected
// payload bytes / drop events as it sends frames, a monitor pops and
// compares whenever the DUT presents out_valid or out_drop.

module tb_mac_rx_fcs_check;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_err = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_good;
    logic [3:0] out_status;
    logic       out_drop;
`ifdef MAC_RX_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_good, stat_crc_err, stat_len_err, stat_drop;
`endif

    mac_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_err     (in_err),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_good   (out_good),
        .out_status (out_status),
        .out_drop   (out_drop)
`ifdef MAC_RX_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_good    (stat_good),
        .stat_crc_err (stat_crc_err),
        .stat_len_err (stat_len_err),
        .stat_drop    (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       drop;
        logic [7:0] data;
        logic       last;
        logic [3:0] status;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_b(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Monitor: compare every DUT output event against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("kind_valid_vs_drop", 0, int'(e.drop));
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    if (e.last) begin
                        chk("out_status", out_status, e.status);
                        chk("out_good", out_good, (e.status == 4'd0));
                    end
                end
            end
            if (out_drop) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_drop", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("kind_drop", 1, int'(e.drop));
                end
            end
        end
    end

    // total: frame length incl. FCS (<=4 means raw bytes, expect a drop).
    // gap: idle cycles after each byte. flip_idx/err_idx: -1 for none.
    // stop_at: send only the first stop_at bytes (-1 = whole frame).
    task automatic send_frame(input int total, input int gap, input int flip_idx,
                              input int err_idx, input logic [3:0] exp_st,
                              input int stop_at, input bit b2b);
        logic [7:0]  b[$];
        logic [31:0] c, fcs;
        exp_t        e;
        int          n;
        b = {};
        c = 32'hFFFFFFFF;
        if (total <= 4) begin
            for (int i = 0; i < total; i++) b.push_back(8'(8'hA0 + i));
        end else begin
            for (int i = 0; i < total - 4; i++) begin
                b.push_back(8'(i));
                c = crc_b(c, 8'(i));
            end
            fcs = ~c;
            for (int i = 0; i < 4; i++) b.push_back(fcs[8*i +: 8]);
        end
        if (flip_idx >= 0) b[flip_idx] = b[flip_idx] ^ 8'h01;
        n = (stop_at >= 0) ? stop_at : total;
        for (int i = 0; i < n; i++) begin
            e = '0;
            if (i >= 4) begin
                e.data   = b[i-4];
                e.last   = (i == total - 1);
                e.status = (i == total - 1) ? exp_st : 4'd0;
                sbq.push_back(e);
            end else if (i == total - 1) begin
                e.drop = 1'b1;
                sbq.push_back(e);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = (i == total - 1);
            in_err   = (i == err_idx);
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
            end
        end
        if (!b2b) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(name, sbq.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_good", out_good, 0);
        chk("reset_out_status", out_status, 0);
        chk("reset_out_drop", out_drop, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // good 64-byte frame, in_valid every 2nd cycle
        send_frame(64, 1, -1, -1, 4'b0000, -1, 1'b0);
        drain("drain_good64");
        // byte 10 corrupted -> crc error
        send_frame(64, 0, 10, -1, 4'b0001, -1, 1'b0);
        drain("drain_crc_err");
        // 20-byte runt
        send_frame(20, 0, -1, -1, 4'b0010, -1, 1'b0);
        drain("drain_runt20");
        // 5-byte frame: one payload byte, runt
        send_frame(5, 1, -1, -1, 4'b0010, -1, 1'b0);
        drain("drain_len5");
        // 1522-byte giant
        send_frame(1522, 0, -1, -1, 4'b0100, -1, 1'b0);
        drain("drain_giant");
        // short frames -> drop
        send_frame(3, 0, -1, -1, 4'b0000, -1, 1'b0);
        drain("drain_drop3");
        send_frame(4, 1, -1, -1, 4'b0000, -1, 1'b0);
        send_frame(1, 0, -1, -1, 4'b0000, -1, 1'b0);
        drain("drain_drop4_1");
        // back-to-back good frames
        send_frame(64, 0, -1, -1, 4'b0000, -1, 1'b1);
        send_frame(64, 0, -1, -1, 4'b0000, -1, 1'b0);
        drain("drain_b2b");
        // PHY error on byte 30
        send_frame(64, 0, -1, 30, 4'b1000, -1, 1'b0);
        drain("drain_phy_err");
        // reset mid-frame after 40 bytes, then a clean frame
        send_frame(64, 0, -1, -1, 4'b0000, 40, 1'b0);
        drain("drain_pre_abort");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_out_drop", out_drop, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(64, 0, -1, -1, 4'b0000, -1, 1'b0);
        drain("drain_post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
